post_code_capture: RTL and testbench
====================================

// Module: post_code_capture
// PURPOSE
//  Next-generation ISA POST-code snooper. Decodes byte writes to a parametrised I/O port and commits one
//  code per ISA write cycle. Drives ASCII hex digits plus a timed "present" flag to the overlay renderer.
//  Keeps a circular history of the last HIST_DEPTH codes, readable by index for a scrolling boot-trace overlay.
// PARAMETERS
//  BASE_ADDR   20'h80          I/O address decoded as the POST port (full 20-bit compare)
//  SHOW_CYCLES 28'd143180000   clk cycles post_code_present stays high after a commit (5 s @ 28.636 MHz)
//  HIST_DEPTH  8               history entries; power of two, >= 2
//  IDX_W       3               $clog2(HIST_DEPTH)
// PORTS
//  clk                   in   1      system clock (28.636 MHz)
//  reset                 in   1      synchronous, active-high reset
//  isa_addr_en           in   1      ISA AEN, active low qualifies I/O cycle
//  isa_io_write          in   1      ISA IOW#, active low
//  isa_addr              in   20     ISA address
//  isa_data              in   8      ISA data bus
//  hist_idx              in   IDX_W  history read index; 0 = most recent code
//  post_code_present     out  1      current code shown on overlay
//  post_code_high_digit  out  8      ASCII of code[7:4]
//  post_code_low_digit   out  8      ASCII of code[3:0]
//  post_code_raw         out  8      last committed code byte
//  hist_count            out  IDX_W+1  valid history entries, saturates at HIST_DEPTH
//  hist_overflow         out  1      sticky: at least one entry has been overwritten
//  hist_valid            out  1      registered: hist_idx < hist_count
//  hist_high_digit       out  8      registered ASCII of entry[hist_idx][7:4]
//  hist_low_digit        out  8      registered ASCII of entry[hist_idx][3:0]
// BEHAVIOUR
//  - cs = (isa_addr == BASE_ADDR) & ~isa_addr_en & ~isa_io_write; sampled into cs_q each clk.
//  - While cs=1: data_q <= isa_data every cycle, so the last bus value of the cycle wins.
//  - Commit strobe = cs_q & ~cs (cs falling edge); exactly one commit per ISA write, however long cs holds.
//  - Commit latency: outputs update on the clk edge after the first cycle cs is seen low.
//  - On commit: post_code_raw <= data_q; digits <= nibble<=9 ? 8'h30+n : 8'h37+n ('0'-'9','A'-'F').
//    post_code_present <= 1; timer <= 0; history push (see CONFIGURATION).
//  - Timer: counts while present=1 and no commit. present <= 0 on the edge where timer == SHOW_CYCLES-1,
//    so present is high exactly SHOW_CYCLES cycles after a commit. Commit and expiry on the same cycle: commit wins.
//  - History: HIST_DEPTH x 8 RAM, wr_ptr wraps modulo HIST_DEPTH. Push writes at wr_ptr, then wr_ptr++.
//    hist_count++ until HIST_DEPTH. A push when hist_count==HIST_DEPTH sets hist_overflow (cleared only by reset).
//  - Read: entry = mem[wr_ptr-1-hist_idx] (mod HIST_DEPTH), registered, 1-cycle latency.
//    Uses pre-edge wr_ptr/mem state; a push in the same cycle is visible next cycle.
//    When hist_valid=0, hist digits = 8'h2D ('-').
//  - Reset (any time, including mid-ISA-cycle): present=1, digits=8'h30/8'h30, raw=8'h00, timer=0, cs_q=0,
//    data_q=0, wr_ptr=0, hist_count=0, hist_overflow=0, hist_valid=0, hist digits=8'h2D.
//    A cs held across reset deassertion does not commit until a fresh rise and fall.
//  - RAM contents are not reset; hist_count gates validity.
// CONFIGURATION
//  - POST_CODE_DEDUP_EN defined: a commit whose byte equals the most recent history entry (hist_count>0)
//    still updates digits/raw/present/timer but does NOT push into history.
//  - POST_CODE_DEDUP_EN undefined: every commit pushes. Port list identical in both builds.
// TESTING
//  1. Reset -> present=1, digits 0x30/0x30, raw=0x00, hist_count=0, hist_valid=0, hist digits 0x2D.
//  2. Write 0xA5 to 0x80, cs held 4 clks -> single commit: raw=0xA5, digits 0x41/0x35, hist_count=1,
//     hist_idx=0 gives 'A','5' next clk.
//  3. Write 0x12 to 0x81; write to 0x80 with isa_addr_en=1; write to 0x80 with isa_io_write=1
//     -> no commit, all outputs unchanged.
//  4. SHOW_CYCLES=16: commit -> present high exactly 16 clks then 0. Re-commit at clk 10 -> present high
//     16 more clks. Commit coinciding with expiry -> present stays 1.
//  5. HIST_DEPTH=8: commits 0x00..0x09 -> hist_count=8, hist_overflow=1, idx0="09", idx7="02".
//     Reset mid-sequence -> hist_count=0.
//  6. Commits 0x3C,0x3C,0x3D -> with POST_CODE_DEDUP_EN hist_count=2 (idx0="3D", idx1="3C");
//     without it hist_count=3. Timer restarts on all three in both builds.

Source files
------------

// File: rtl/post_code_capture.sv
// post_code_capture: ISA POST-code snooper for the boot overlay.
// Captures byte writes to the BASE_ADDR I/O port and commits one code on
// the falling edge of each qualified ISA write. It provides ASCII hex digits,
// a "present" flag that stays high for a fixed time, and a circular history
// that can be read by index (0 = most recent).
// Optional build macro: POST_CODE_DEDUP_EN. When it is defined, a code equal
// to the newest history entry refreshes the display but is not pushed again.
module post_code_capture #(
  parameter logic [19:0] BASE_ADDR   = 20'h00080,
  parameter logic [27:0] SHOW_CYCLES = 28'd143180000,
  parameter int          HIST_DEPTH  = 8,
  parameter int          IDX_W       = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             isa_addr_en,
  input  logic             isa_io_write,
  input  logic [19:0]      isa_addr,
  input  logic [7:0]       isa_data,
  input  logic [IDX_W-1:0] hist_idx,
  output logic             post_code_present,
  output logic [7:0]       post_code_high_digit,
  output logic [7:0]       post_code_low_digit,
  output logic [7:0]       post_code_raw,
  output logic [IDX_W:0]   hist_count,
  output logic             hist_overflow,
  output logic             hist_valid,
  output logic [7:0]       hist_high_digit,
  output logic [7:0]       hist_low_digit
);

  localparam logic [27:0]      SHOW_LAST = SHOW_CYCLES - 28'd1;
  localparam logic [IDX_W:0]   HIST_FULL = (IDX_W + 1)'(HIST_DEPTH);
  localparam logic [IDX_W-1:0] PTR_ONE   = IDX_W'(1);
  localparam logic [7:0]       DASH      = 8'h2D;

  // Convert one nibble to its ASCII hex character ('0'-'9', 'A'-'F').
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib <= 4'd9) begin
      ch = 8'h30 + {4'h0, nib};
    end else begin
      ch = 8'h37 + {4'h0, nib};
    end
    return ch;
  endfunction

  // Bus front end state.
  logic       cs_s;
  logic       commit_s;
  logic       cs_q,    cs_d;
  logic       armed_q, armed_d;
  logic [7:0] data_q,  data_d;

  // Display state.
  logic        present_q, present_d;
  logic [27:0] timer_q,   timer_d;
  logic [7:0]  raw_q,     raw_d;
  logic [7:0]  high_q,    high_d;
  logic [7:0]  low_q,     low_d;

  // History state.
  logic [7:0]       mem_q [HIST_DEPTH];
  logic             dup_s;
  logic             push_s;
  logic [IDX_W-1:0] rd_addr_s;
  logic [IDX_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [IDX_W:0]   count_q,    count_d;
  logic             overflow_q, overflow_d;
  logic             hvalid_q,   hvalid_d;
  logic [7:0]       hhigh_q,    hhigh_d;
  logic [7:0]       hlow_q,     hlow_d;

  // Decode the POST port and detect the end of a write cycle.
  // armed_q blocks a commit until cs has been seen low after reset. This keeps
  // a cycle that was already in progress during reset from committing.
  always_comb begin
    cs_s     = (isa_addr == BASE_ADDR) & ~isa_addr_en & ~isa_io_write;
    cs_d     = cs_s;
    commit_s = cs_q & ~cs_s & armed_q;
    if (cs_s) begin
      data_d  = isa_data;
      armed_d = armed_q;
    end else begin
      data_d  = data_q;
      armed_d = 1'b1;
    end
  end

  // Register the bus front end. armed_q samples the live cs during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q    <= 1'b0;
      armed_q <= ~cs_s;
      data_q  <= 8'h00;
    end else begin
      cs_q    <= cs_d;
      armed_q <= armed_d;
      data_q  <= data_d;
    end
  end

  // Update the display on commit and time out the present flag. A commit
  // takes priority over expiry in the same cycle.
  always_comb begin
    present_d = present_q;
    timer_d   = timer_q;
    raw_d     = raw_q;
    high_d    = high_q;
    low_d     = low_q;
    if (commit_s) begin
      present_d = 1'b1;
      timer_d   = 28'd0;
      raw_d     = data_q;
      high_d    = hex_ascii(data_q[7:4]);
      low_d     = hex_ascii(data_q[3:0]);
    end else if (present_q) begin
      if (timer_q == SHOW_LAST) begin
        present_d = 1'b0;
        timer_d   = 28'd0;
      end else begin
        timer_d   = timer_q + 28'd1;
      end
    end else begin
      timer_d = 28'd0;
    end
  end

  // Register the display state. After reset the display shows "00" and is marked present.
  always_ff @(posedge clk) begin
    if (reset) begin
      present_q <= 1'b1;
      timer_q   <= 28'd0;
      raw_q     <= 8'h00;
      high_q    <= 8'h30;
      low_q     <= 8'h30;
    end else begin
      present_q <= present_d;
      timer_q   <= timer_d;
      raw_q     <= raw_d;
      high_q    <= high_d;
      low_q     <= low_d;
    end
  end

`ifdef POST_CODE_DEDUP_EN
  logic [IDX_W-1:0] last_addr_s;

  // Suppress a history push when the code repeats the newest entry.
  always_comb begin
    last_addr_s = wr_ptr_q - PTR_ONE;
    if (count_q != {(IDX_W + 1){1'b0}}) begin
      dup_s = (mem_q[last_addr_s] == data_q);
    end else begin
      dup_s = 1'b0;
    end
  end
`else
  // Every commit is pushed into the history.
  always_comb begin
    dup_s = 1'b0;
  end
`endif

  // Compute the history push, the pointer and count updates, and the indexed read.
  // The read uses the state from before the edge, so a push in the same cycle
  // becomes visible one cycle later.
  always_comb begin
    push_s     = commit_s & ~dup_s;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q == HIST_FULL) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + {{IDX_W{1'b0}}, 1'b1};
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    rd_addr_s = wr_ptr_q - PTR_ONE - hist_idx;
    hvalid_d  = ({1'b0, hist_idx} < count_q);
    if (hvalid_d) begin
      hhigh_d = hex_ascii(mem_q[rd_addr_s][7:4]);
      hlow_d  = hex_ascii(mem_q[rd_addr_s][3:0]);
    end else begin
      hhigh_d = DASH;
      hlow_d  = DASH;
    end
  end

  // Write the history RAM. Its contents are not reset; hist_count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= data_q;
    end
  end

  // Register the history bookkeeping and the read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {IDX_W{1'b0}};
      count_q    <= {(IDX_W + 1){1'b0}};
      overflow_q <= 1'b0;
      hvalid_q   <= 1'b0;
      hhigh_q    <= DASH;
      hlow_q     <= DASH;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hvalid_q   <= hvalid_d;
      hhigh_q    <= hhigh_d;
      hlow_q     <= hlow_d;
    end
  end

  assign post_code_present    = present_q;
  assign post_code_high_digit = high_q;
  assign post_code_low_digit  = low_q;
  assign post_code_raw        = raw_q;
  assign hist_count           = count_q;
  assign hist_overflow        = overflow_q;
  assign hist_valid           = hvalid_q;
  assign hist_high_digit      = hhigh_q;
  assign hist_low_digit       = hlow_q;

endmodule

// File: tb/tb_post_code_capture.sv
// Testbench for post_code_capture.
// The reference model keeps the committed codes in a queue (newest first),
// counts the clocks since the last commit, and forms hex characters from a
// lookup string.
module tb_post_code_capture;

  localparam int SHOW  = 16;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             isa_addr_en;
  logic             isa_io_write;
  logic [19:0]      isa_addr;
  logic [7:0]       isa_data;
  logic [IDX_W-1:0] hist_idx;
  logic             post_code_present;
  logic [7:0]       post_code_high_digit;
  logic [7:0]       post_code_low_digit;
  logic [7:0]       post_code_raw;
  logic [IDX_W:0]   hist_count;
  logic             hist_overflow;
  logic             hist_valid;
  logic [7:0]       hist_high_digit;
  logic [7:0]       hist_low_digit;

  post_code_capture #(
    .BASE_ADDR  (20'h00080),
    .SHOW_CYCLES(28'd16),
    .HIST_DEPTH (8),
    .IDX_W      (3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .isa_addr_en         (isa_addr_en),
    .isa_io_write        (isa_io_write),
    .isa_addr            (isa_addr),
    .isa_data            (isa_data),
    .hist_idx            (hist_idx),
    .post_code_present   (post_code_present),
    .post_code_high_digit(post_code_high_digit),
    .post_code_low_digit (post_code_low_digit),
    .post_code_raw       (post_code_raw),
    .hist_count          (hist_count),
    .hist_overflow       (hist_overflow),
    .hist_valid          (hist_valid),
    .hist_high_digit     (hist_high_digit),
    .hist_low_digit      (hist_low_digit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] hq[$];
  int         pushes = 0;
  int         since  = 0;
  logic [7:0] m_raw  = 8'h00;
  string      HEX    = "0123456789ABCDEF";

  function automatic logic [7:0] hexch(input logic [3:0] n);
    return HEX.getc(int'(n));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] code);
    bit skip;
    skip = 1'b0;
`ifdef POST_CODE_DEDUP_EN
    if (hq.size() > 0) skip = (hq[0] == code);
`endif
    if (!skip) begin
      hq.push_front(code);
      pushes++;
      if (hq.size() > DEPTH) void'(hq.pop_back());
    end
  endtask

  // One clock: advance the model as the edge occurs, then settle 1 time unit.
  task automatic tick(input bit commit, input logic [7:0] code);
    @(posedge clk);
    if (reset) begin
      hq.delete();
      pushes = 0;
      since  = 0;
      m_raw  = 8'h00;
    end else if (commit) begin
      m_raw = code;
      since = 0;
      model_push(code);
    end else if (since < SHOW) begin
      since++;
    end
    #1;
  endtask

  task automatic idle();
    isa_addr_en  = 1'b1;
    isa_io_write = 1'b1;
    isa_addr     = 20'h00000;
    isa_data     = 8'($urandom);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  // Drive one ISA I/O write cycle with cs held for `hold` clocks and random
  // data except in the last cycle, then release the bus.
  task automatic isa_write(input logic [19:0] a, input bit aen, input bit iow,
                           input logic [7:0] code, input int hold);
    bit hit;
    hit          = (a == 20'h00080) && !aen && !iow;
    isa_addr     = a;
    isa_addr_en  = aen;
    isa_io_write = iow;
    for (int i = 0; i < hold; i++) begin
      isa_data = (i == hold - 1) ? code : 8'($urandom);
      tick(1'b0, 8'h00);
    end
    idle();
    tick(hit, code);
  endtask

  task automatic check_main(input string tag);
    chk({tag, "_present"}, 32'(post_code_present), 32'(since < SHOW));
    chk({tag, "_raw"},     32'(post_code_raw), 32'(m_raw));
    chk({tag, "_hi"},      32'(post_code_high_digit), 32'(hexch(m_raw[7:4])));
    chk({tag, "_lo"},      32'(post_code_low_digit), 32'(hexch(m_raw[3:0])));
    chk({tag, "_count"},   32'(hist_count), 32'(hq.size()));
    chk({tag, "_ovf"},     32'(hist_overflow), 32'(pushes > DEPTH));
  endtask

  task automatic check_hist(input string tag, input int idx);
    bit         v;
    logic [7:0] hi;
    logic [7:0] lo;
    hist_idx = idx[IDX_W-1:0];
    tick(1'b0, 8'h00);
    v  = (idx < hq.size());
    hi = v ? hexch(hq[idx][7:4]) : 8'h2D;
    lo = v ? hexch(hq[idx][3:0]) : 8'h2D;
    chk({tag, "_hvalid"}, 32'(hist_valid), 32'(v));
    chk({tag, "_hhi"},    32'(hist_high_digit), 32'(hi));
    chk({tag, "_hlo"},    32'(hist_low_digit), 32'(lo));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    hist_idx = '0;
    idle();

    // Reset state
    do_reset();
    check_main("rst");
    chk("rst_present_c", 32'(post_code_present), 32'd1);
    chk("rst_hi_c", 32'(post_code_high_digit), 32'h30);
    chk("rst_hvalid", 32'(hist_valid), 32'd0);
    chk("rst_hhi", 32'(hist_high_digit), 32'h2D);
    chk("rst_hlo", 32'(hist_low_digit), 32'h2D);

    // Single commit with a long cs hold
    isa_write(20'h00080, 1'b0, 1'b0, 8'hA5, 4);
    check_main("a5");
    chk("a5_raw_c", 32'(post_code_raw), 32'hA5);
    chk("a5_hi_c", 32'(post_code_high_digit), 32'h41);
    chk("a5_lo_c", 32'(post_code_low_digit), 32'h35);
    chk("a5_count_c", 32'(hist_count), 32'd1);
    check_hist("a5", 0);
    chk("a5_hhi_c", 32'(hist_high_digit), 32'h41);

    // Non-qualifying cycles produce no commit
    isa_write(20'h00081, 1'b0, 1'b0, 8'h12, 2);
    isa_write(20'h00080, 1'b1, 1'b0, 8'h12, 2);
    isa_write(20'h00080, 1'b0, 1'b1, 8'h12, 2);
    check_main("nocommit");
    chk("nocommit_raw_c", 32'(post_code_raw), 32'hA5);
    chk("nocommit_count_c", 32'(hist_count), 32'd1);

    // Present window: high for exactly SHOW clocks after a commit
    isa_write(20'h00080, 1'b0, 1'b0, 8'h11, 1);
    for (int k = 1; k <= SHOW + 1; k++) begin
      tick(1'b0, 8'h00);
      chk("win1", 32'(post_code_present), 32'(k < SHOW));
    end
    // A re-commit 10 clocks later restarts the window
    isa_write(20'h00080, 1'b0, 1'b0, 8'h22, 1);
    idle_ticks(8);
    isa_write(20'h00080, 1'b0, 1'b0, 8'h23, 1);
    for (int k = 1; k <= SHOW + 1; k++) begin
      tick(1'b0, 8'h00);
      chk("win2", 32'(post_code_present), 32'(k < SHOW));
    end
    // A commit on the expiry edge keeps present high
    isa_write(20'h00080, 1'b0, 1'b0, 8'h33, 1);
    idle_ticks(SHOW - 2);
    isa_write(20'h00080, 1'b0, 1'b0, 8'h44, 1);
    chk("coinc_present", 32'(post_code_present), 32'd1);
    check_main("coinc");
    for (int k = 1; k < SHOW; k++) begin
      tick(1'b0, 8'h00);
      chk("win3", 32'(post_code_present), 32'd1);
    end

    // History wrap and overflow
    do_reset();
    for (int i = 0; i < 10; i++) isa_write(20'h00080, 1'b0, 1'b0, 8'(i), 1 + (i % 3));
    check_main("wrap");
    chk("wrap_count_c", 32'(hist_count), 32'd8);
    chk("wrap_ovf_c", 32'(hist_overflow), 32'd1);
    check_hist("wrap0", 0);
    chk("wrap0_c", 32'({hist_high_digit, hist_low_digit}), 32'h3039);
    check_hist("wrap7", 7);
    chk("wrap7_c", 32'({hist_high_digit, hist_low_digit}), 32'h3032);

    // Reset in the middle of a write cycle, with cs held across the reset release
    isa_addr     = 20'h00080;
    isa_addr_en  = 1'b0;
    isa_io_write = 1'b0;
    isa_data     = 8'h77;
    tick(1'b0, 8'h00);
    reset = 1'b1;
    tick(1'b0, 8'h00);
    reset = 1'b0;
    idle_ticks(2);
    idle();
    tick(1'b0, 8'h00);
    check_main("midrst");
    chk("midrst_count_c", 32'(hist_count), 32'd0);
    chk("midrst_raw_c", 32'(post_code_raw), 32'h00);
    isa_write(20'h00080, 1'b0, 1'b0, 8'h5A, 2);
    check_main("after_midrst");

    // Repeated code: with dedup the repeat is not pushed again
    do_reset();
    isa_write(20'h00080, 1'b0, 1'b0, 8'h3C, 2);
    isa_write(20'h00080, 1'b0, 1'b0, 8'h3C, 2);
    idle_ticks(10);
    isa_write(20'h00080, 1'b0, 1'b0, 8'h3D, 2);
    check_main("dedup");
`ifdef POST_CODE_DEDUP_EN
    chk("dedup_count_c", 32'(hist_count), 32'd2);
`else
    chk("dedup_count_c", 32'(hist_count), 32'd3);
`endif
    check_hist("dedup0", 0);
    chk("dedup0_c", 32'({hist_high_digit, hist_low_digit}), 32'h3344);
    check_hist("dedup1", 1);
    chk("dedup1_c", 32'({hist_high_digit, hist_low_digit}), 32'h3343);
    check_hist("dedup2", 2);
    for (int k = 0; k < SHOW - 4; k++) begin
      tick(1'b0, 8'h00);
      chk("dedup_win", 32'(post_code_present), 32'(since < SHOW));
    end

    // Randomized traffic checked against the model
    for (int it = 0; it < 60; it++) begin
      int         sel;
      logic [19:0] a;
      logic [7:0]  code;
      sel = $urandom_range(0, 9);
      if (sel < 7) a = 20'h00080;
      else if (sel == 7) a = 20'h00081;
      else a = 20'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0) code = 8'h3C;
      else if (sel == 1) code = 8'h3D;
      else code = 8'($urandom);
      isa_write(a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), code,
                $urandom_range(1, 4));
      idle_ticks($urandom_range(0, 6));
      check_main("rnd");
      check_hist("rnd", $urandom_range(0, DEPTH - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
